// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/bubble control, exception freeze,
// stall/bubble conflict flag and saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int          DATA_W        = 192,
    parameter int          CNT_W         = 16,
    parameter int          FREEZE_ON_EXC = 1,
    parameter logic [3:0]  NOP_ICODE     = 4'h1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              bubble,
    input  logic              cnt_clr,
    input  logic [2:0]        in_stat,
    input  logic [3:0]        in_icode,
    input  logic [DATA_W-1:0] in_data,
    output logic [2:0]        out_stat,
    output logic [3:0]        out_icode,
    output logic [DATA_W-1:0] out_data,
    output logic              frozen,
    output logic              ctrl_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [2:0]       STAT_AOK = 3'd1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic             FRZ_EN   = (FREEZE_ON_EXC != 0);

    logic hold;
    logic do_bubble;
    logic do_load;
    logic stall_inc;

    // Priority: frozen, then stall, then bubble, then normal load.
    always_comb begin
        hold      = frozen | stall;
        do_bubble = ~hold & bubble;
        do_load   = ~hold & ~bubble;
        stall_inc = ~frozen & stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_stat  <= STAT_AOK;
            out_icode <= NOP_ICODE;
            out_data  <= '0;
        end else if (do_bubble) begin
            out_stat  <= STAT_AOK;
            out_icode <= NOP_ICODE;
            out_data  <= '0;
        end else if (do_load) begin
            out_stat  <= in_stat;
            out_icode <= in_icode;
            out_data  <= in_data;
        end
    end

    // Freeze is sticky until reset; only a real load of a non-AOK status sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen <= 1'b0;
        end else if (FRZ_EN && do_load && (in_stat != STAT_AOK)) begin
            frozen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_err <= 1'b0;
        end else begin
            ctrl_err <= ~frozen & stall & bubble;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (do_bubble && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors push hand-computed
// expectations; a monitor pops and compares one entry per clock edge.
module tb_pipe_stage_reg;

    localparam int DW = 192;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          stall, bubble, cnt_clr;
    logic [2:0]    in_stat;
    logic [3:0]    in_icode;
    logic [DW-1:0] in_data;

    logic [2:0]    out_stat;
    logic [3:0]    out_icode;
    logic [DW-1:0] out_data;
    logic          frozen, ctrl_err;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    logic [2:0]    nf_stat;
    logic [3:0]    nf_icode;
    logic [DW-1:0] nf_data;
    logic          nf_frozen, nf_ctrl_err;
    logic [CW-1:0] nf_scnt, nf_bcnt;

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW), .FREEZE_ON_EXC(1), .NOP_ICODE(4'h1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble), .cnt_clr(cnt_clr),
        .in_stat(in_stat), .in_icode(in_icode), .in_data(in_data),
        .out_stat(out_stat), .out_icode(out_icode), .out_data(out_data),
        .frozen(frozen), .ctrl_err(ctrl_err), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW), .FREEZE_ON_EXC(0), .NOP_ICODE(4'h1)) dut_nf (
        .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble), .cnt_clr(cnt_clr),
        .in_stat(in_stat), .in_icode(in_icode), .in_data(in_data),
        .out_stat(nf_stat), .out_icode(nf_icode), .out_data(nf_data),
        .frozen(nf_frozen), .ctrl_err(nf_ctrl_err), .stall_cnt(nf_scnt), .bubble_cnt(nf_bcnt)
    );

    typedef struct {
        int            id;
        logic [2:0]    stat;
        logic [3:0]    icode;
        logic [DW-1:0] data;
        logic          frz;
        logic          cerr;
        logic [CW-1:0] scnt;
        logic [CW-1:0] bcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_id = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " stat"},  DW'(out_stat),   DW'(1));
        chk({tag, " icode"}, DW'(out_icode),  DW'(1));
        chk({tag, " data"},  out_data,        '0);
        chk({tag, " frz"},   DW'(frozen),     '0);
        chk({tag, " cerr"},  DW'(ctrl_err),   '0);
        chk({tag, " scnt"},  DW'(stall_cnt),  '0);
        chk({tag, " bcnt"},  DW'(bubble_cnt), '0);
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must show.
    task automatic step(input logic s, input logic b, input logic c,
                        input logic [2:0] ist, input logic [3:0] iic, input logic [DW-1:0] idt,
                        input logic [2:0] est, input logic [3:0] eic, input logic [DW-1:0] edt,
                        input logic efz, input logic eer, input int esc, input int ebc);
        exp_t e;
        @(negedge clk);
        stall = s; bubble = b; cnt_clr = c;
        in_stat = ist; in_icode = iic; in_data = idt;
        step_id++;
        e.id = step_id; e.stat = est; e.icode = eic; e.data = edt;
        e.frz = efz; e.cerr = eer; e.scnt = CW'(esc); e.bcnt = CW'(ebc);
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison set per rising edge that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("s%0d stat", e.id),  DW'(out_stat),   DW'(e.stat));
                chk($sformatf("s%0d icode", e.id), DW'(out_icode),  DW'(e.icode));
                chk($sformatf("s%0d data", e.id),  out_data,        e.data);
                chk($sformatf("s%0d frz", e.id),   DW'(frozen),     DW'(e.frz));
                chk($sformatf("s%0d cerr", e.id),  DW'(ctrl_err),   DW'(e.cerr));
                chk($sformatf("s%0d scnt", e.id),  DW'(stall_cnt),  DW'(e.scnt));
                chk($sformatf("s%0d bcnt", e.id),  DW'(bubble_cnt), DW'(e.bcnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; bubble = 1'b0; cnt_clr = 1'b0;
        in_stat = 3'd1; in_icode = 4'h0; in_data = '0;
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Load and back-to-back streaming
        step(0,0,0, 1,6,'hABCD, 1,6,'hABCD, 0,0, 0,0);
        step(0,0,0, 1,3,'h1111, 1,3,'h1111, 0,0, 0,0);
        step(0,0,0, 1,7,'h2222, 1,7,'h2222, 0,0, 0,0);
        // Three stalls hold, then a bubble
        step(1,0,0, 1,9,'h9999, 1,7,'h2222, 0,0, 1,0);
        step(1,0,0, 1,9,'h9999, 1,7,'h2222, 0,0, 2,0);
        step(1,0,0, 1,9,'h9999, 1,7,'h2222, 0,0, 3,0);
        step(0,1,0, 1,9,'h9999, 1,1,'h0,    0,0, 3,1);
        step(0,0,0, 1,5,'h5555, 1,5,'h5555, 0,0, 3,1);
        // Stall+bubble conflict: hold, one-cycle ctrl_err
        step(1,1,0, 1,8,'h8888, 1,5,'h5555, 0,1, 4,1);
        step(0,0,0, 1,2,'h2,    1,2,'h2,    0,0, 4,1);
        // Clear beats the same-cycle bubble increment, bubble still loads
        step(0,1,1, 1,9,'h9999, 1,1,'h0,    0,0, 0,0);
        // Saturation over 20 stalls
        for (int i = 0; i < 20; i++)
            step(1,0,0, 1,9,'h9999, 1,1,'h0, 0,0, (i + 1 > 15) ? 15 : i + 1, 0);
        step(1,0,1, 1,9,'h9999, 1,1,'h0,    0,0, 0,0);
        step(0,0,0, 1,4,'h4444, 1,4,'h4444, 0,0, 0,0);
        // Exception load freezes; everything afterwards is ignored
        step(0,0,0, 2,0,'hDEAD, 2,0,'hDEAD, 1,0, 0,0);
        step(0,0,0, 1,6,'h6666, 2,0,'hDEAD, 1,0, 0,0);
        chk("nofreeze frz",  DW'(nf_frozen), '0);
        chk("nofreeze stat", DW'(nf_stat),   DW'(2));
        step(1,0,0, 1,6,'h6666, 2,0,'hDEAD, 1,0, 0,0);
        step(0,1,0, 1,6,'h6666, 2,0,'hDEAD, 1,0, 0,0);
        step(1,1,0, 1,6,'h6666, 2,0,'hDEAD, 1,0, 0,0);
        step(0,0,0, 3,7,'h7777, 2,0,'hDEAD, 1,0, 0,0);
        chk("nofreeze frz2", DW'(nf_frozen), '0);

        // Reset pulse out of freeze acts immediately
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_frz");
        step(0,0,0, 1,6,'hABCD, 1,6,'hABCD, 0,0, 0,0);
        rst_n = 1'b1;
        step(0,0,0, 1,3,'h3333, 1,3,'h3333, 0,0, 0,0);

        // Async reset during a stall, before the next edge
        step(1,0,0, 1,9,'h9999, 1,3,'h3333, 0,0, 1,0);
        step(1,0,0, 1,9,'h9999, 1,3,'h3333, 0,0, 2,0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_stall");
        step(0,0,0, 1,5,'hBEEF, 1,5,'hBEEF, 0,0, 0,0);
        rst_n = 1'b1;
        step(0,1,0, 1,5,'h0,    1,1,'h0,    0,0, 0,1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_W, default 192, width of the stage payload (valC/valA/valB/dst/src fields concatenated by the instantiating stage).
REQ-002 Parameter: CNT_W, default 16, width of each performance counter.
REQ-003 Parameter: FREEZE_ON_EXC, default 1, when 1 the register freezes after capturing a non-AOK status.
REQ-004 Parameter: NOP_ICODE, default 4'h1, icode inserted on a bubble.
REQ-005 Port: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port: rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 Port: stall, input, 1, hold current contents this cycle.
REQ-008 Port: bubble, input, 1, load a NOP bubble this cycle.
REQ-009 Port: cnt_clr, input, 1, synchronous clear of both counters.
REQ-010 Port: in_stat, input, 3, upstream status (1=AOK, 2=HLT, 3=ADR, 4=INS).
REQ-011 Port: in_icode, input, 4, upstream instruction code.
REQ-012 Port: in_data, input, DATA_W, upstream payload.
REQ-013 Port: out_stat, output, 3, registered status.
REQ-014 Port: out_icode, output, 4, registered icode.
REQ-015 Port: out_data, output, DATA_W, registered payload.
REQ-016 Port: frozen, output, 1, register has latched an exception and ignores loads.
REQ-017 Port: ctrl_err, output, 1, registered one-cycle pulse: stall and bubble asserted together.
REQ-018 Port: stall_cnt, output, CNT_W, count of cycles held by stall.
REQ-019 Port: bubble_cnt, output, CNT_W, count of bubbles inserted.

Function
REQ-020 The block SHALL select each cycle, in priority order: frozen -> hold; stall -> hold; bubble -> load bubble; otherwise -> load inputs.
REQ-021 A load SHALL copy in_stat/in_icode/in_data to the outputs with exactly one cycle latency.
REQ-022 A bubble SHALL set out_stat=1 (AOK), out_icode=NOP_ICODE, out_data=0.
REQ-023 A hold SHALL leave out_stat, out_icode and out_data unchanged.
REQ-024 With stall=1 and bubble=1 in the same cycle, the block SHALL hold (stall wins) and assert ctrl_err the following cycle for exactly one cycle.
REQ-025 With FREEZE_ON_EXC=1, frozen SHALL rise in the same edge that loads in_stat != 1, and remain 1 until reset.
REQ-026 With FREEZE_ON_EXC=0, frozen SHALL remain 0 permanently.
REQ-027 While frozen, stall, bubble and inputs SHALL be ignored; ctrl_err SHALL stay 0; counters SHALL not increment.
REQ-028 stall_cnt SHALL increment by 1 on each non-frozen cycle with stall=1, including the stall-plus-bubble case.
REQ-029 bubble_cnt SHALL increment by 1 on each cycle where a bubble is actually loaded per REQ-020.
REQ-030 Each counter SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-031 cnt_clr=1 SHALL zero both counters at the next edge, taking priority over any same-cycle increment; payload, frozen and ctrl_err SHALL be unaffected.

Reset
REQ-032 rst_n=0 SHALL immediately, independent of clk, force out_stat=1, out_icode=NOP_ICODE, out_data=0, frozen=0, ctrl_err=0, stall_cnt=0, bubble_cnt=0.
REQ-033 Reset asserted mid-freeze or mid-stall SHALL discard all state; the first rising edge after rst_n rises SHALL act per REQ-020 on that edge's inputs.

Verification
REQ-034 Load/latency: in_stat=1, in_icode=6, in_data=0xABCD, stall=bubble=0 -> outputs show 1/6/0xABCD one edge later; a new value each cycle streams back-to-back.
REQ-035 Stall/bubble: hold 3 cycles with stall=1 -> outputs unchanged, stall_cnt=3; then bubble=1 for 1 cycle -> out_icode=1, out_stat=1, out_data=0, bubble_cnt=1.
REQ-036 Conflict: stall=1, bubble=1 for one cycle -> outputs held, ctrl_err=1 for exactly one cycle, stall_cnt+1, bubble_cnt unchanged.
REQ-037 Freeze: load in_stat=2 (HLT) -> frozen=1; then 5 cycles of new inputs, stall and bubble -> outputs stay HLT values, counters unchanged; rst_n pulse low -> reset values immediately.
REQ-038 Saturation/clear: CNT_W=4, stall=1 for 20 cycles -> stall_cnt=15; cnt_clr=1 with stall=1 -> stall_cnt=0 next edge.
REQ-039 Async reset: assert rst_n=0 between clock edges during a stall -> outputs reach reset values before the next clk edge.
